// File: rtl/seg7_pkg.sv
// Shared definitions for the DEBO 7-segment display blocks: segment codes,
// scan FSM states and digit count. Optional feature macro: SEG7_DP_EN.
package seg7_pkg;

  localparam int N_DIG = 4;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0   = 7'b0111111;
  localparam logic [6:0] SEG_1   = 7'b0000110;
  localparam logic [6:0] SEG_2   = 7'b1011011;
  localparam logic [6:0] SEG_3   = 7'b1001111;
  localparam logic [6:0] SEG_4   = 7'b1100110;
  localparam logic [6:0] SEG_5   = 7'b1101101;
  localparam logic [6:0] SEG_6   = 7'b1111101;
  localparam logic [6:0] SEG_7   = 7'b0000111;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1101111;
  localparam logic [6:0] SEG_A   = 7'b1110111;
  localparam logic [6:0] SEG_B   = 7'b1111100;
  localparam logic [6:0] SEG_C   = 7'b0111001;
  localparam logic [6:0] SEG_D   = 7'b1011110;
  localparam logic [6:0] SEG_E   = 7'b1111001;
  localparam logic [6:0] SEG_F   = 7'b1110001;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex-to-7-segment decoder, {g,f,e,d,c,b,a} active-high.
// Reusable by any display client.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// 4-digit 7-segment scan controller with blanking and a one-entry write buffer.
// Define SEG7_DP_EN to add per-digit decimal point storage (wr_dp in, dp out).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clk,
  input  logic       rst,
  // Write port: a transfer happens at a rising edge where wr_valid && wr_ready;
  // the fields must stay stable while wr_valid is high and wr_ready is low,
  // and may change freely in the cycle after a transfer.
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_digit,
  input  logic [3:0] wr_value,
  input  logic       wr_on,
`ifdef SEG7_DP_EN
  input  logic       wr_dp,
  output logic       dp,
`endif
  output logic [6:0] Y,
  output logic [3:0] Dig,
  output logic       dbg_state_o
);

  localparam int CW = $clog2(SLOT_CYC);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(SLOT_CYC - BLANK_CYC - 1);

  scan_state_t                 state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [1:0]                  idx_q, idx_d;
  logic [N_DIG-1:0][3:0]       val_q, val_d;
  logic [N_DIG-1:0]            on_q, on_d;
  logic                        pend_q, pend_d;
  logic [1:0]                  pdig_q, pdig_d;
  logic [3:0]                  pval_q, pval_d;
  logic                        pon_q, pon_d;
  logic [6:0]                  y_q, y_d;
  logic [3:0]                  dig_q, dig_d;
  logic [6:0]                  seg_d;
  logic                        lit_d;
`ifdef SEG7_DP_EN
  logic [N_DIG-1:0]            dpr_q, dpr_d;
  logic                        pdp_q, pdp_d;
  logic                        dpo_q, dpo_d;
`endif

  // Outputs are registered from next-state values so they align with state_q.
  seg7_hex_dec u_dec (
    .hex_i (val_d[idx_d]),
    .seg_o (seg_d)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    val_d   = val_q;
    on_d    = on_q;
    pend_d  = pend_q;
    pdig_d  = pdig_q;
    pval_d  = pval_q;
    pon_d   = pon_q;
`ifdef SEG7_DP_EN
    dpr_d   = dpr_q;
    pdp_d   = pdp_q;
`endif

    if (wr_valid && !pend_q) begin
      pend_d = 1'b1;
      pdig_d = wr_digit;
      pval_d = wr_value;
      pon_d  = wr_on;
`ifdef SEG7_DP_EN
      pdp_d  = wr_dp;
`endif
    end

    if (state_q == BLANK) begin
      // Commit only while dark so a lit digit never changes mid-slot.
      if (pend_q) begin
        val_d[pdig_q] = pval_q;
        on_d[pdig_q]  = pon_q;
`ifdef SEG7_DP_EN
        dpr_d[pdig_q] = pdp_q;
`endif
        pend_d        = 1'b0;
      end
      if (cnt_q == BLANK_LAST) begin
        state_d = DRIVE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      if (cnt_q == DRIVE_LAST) begin
        state_d = BLANK;
        cnt_d   = '0;
        idx_d   = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    lit_d = (state_d == DRIVE) && on_d[idx_d];
    y_d   = lit_d ? seg_d : SEG_OFF;
    dig_d = lit_d ? (4'b0001 << idx_d) : 4'b0000;
`ifdef SEG7_DP_EN
    dpo_d = lit_d && dpr_d[idx_d];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      on_q    <= '0;
      pend_q  <= 1'b0;
      pdig_q  <= '0;
      pval_q  <= '0;
      pon_q   <= 1'b0;
      y_q     <= SEG_OFF;
      dig_q   <= '0;
`ifdef SEG7_DP_EN
      dpr_q   <= '0;
      pdp_q   <= 1'b0;
      dpo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      on_q    <= on_d;
      pend_q  <= pend_d;
      pdig_q  <= pdig_d;
      pval_q  <= pval_d;
      pon_q   <= pon_d;
      y_q     <= y_d;
      dig_q   <= dig_d;
`ifdef SEG7_DP_EN
      dpr_q   <= dpr_d;
      pdp_q   <= pdp_d;
      dpo_q   <= dpo_d;
`endif
    end
  end

  assign wr_ready    = ~pend_q;
  assign Y           = y_q;
  assign Dig         = dig_q;
  assign dbg_state_o = state_q;
`ifdef SEG7_DP_EN
  assign dp          = dpo_q;
`endif

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SLOT_CYC=8, BLANK_CYC=2 (period 32).
// Covers the SEG7_DP_EN build when that macro is defined.
module tb_seg7_scan_ctrl;
  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int PER   = 4 * SLOT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [1:0] wr_digit = '0;
  logic [3:0] wr_value = '0;
  logic       wr_on = 1'b0;
  logic [6:0] Y;
  logic [3:0] Dig;
  logic       dbg_state;
`ifdef SEG7_DP_EN
  logic       wr_dp = 1'b0;
  logic       dp;
`endif

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [1:0] digit;
    logic [3:0] value;
    logic       on;
    logic [3:0] exp_dig;
    logic [6:0] exp_y;
  } vec_t;
  vec_t tbl[16];

  seg7_scan_ctrl #(.SLOT_CYC(SLOT), .BLANK_CYC(BLANK)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_digit    (wr_digit),
    .wr_value    (wr_value),
    .wr_on       (wr_on),
`ifdef SEG7_DP_EN
    .wr_dp       (wr_dp),
    .dp          (dp),
`endif
    .Y           (Y),
    .Dig         (Dig),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at pos %0d: got %b expected %b", name, cyc % PER, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic align(input int pos);
    while (cyc % PER != pos) step();
  endtask

  task automatic write_req(input logic [1:0] d, input logic [3:0] v, input logic on);
    wr_digit = d;
    wr_value = v;
    wr_on    = on;
    wr_valid = 1'b1;
    chk("ready_idle", 7'(wr_ready), 7'd1);
    step();
    wr_valid = 1'b0;
    chk("ready_pending", 7'(wr_ready), 7'd0);
  endtask

  // Checks one full period starting at pos 0; slot s expectations at digs[4s+:4], ys[7s+:7].
  task automatic check_period(input logic [15:0] digs, input logic [27:0] ys);
    int   p;
    int   s;
    logic drv;
    for (int k = 0; k < PER; k++) begin
      p   = cyc % PER;
      s   = p / SLOT;
      drv = (p % SLOT) >= BLANK;
      chk("scan_dig", 7'(Dig), drv ? 7'(digs[s*4 +: 4]) : 7'd0);
      chk("scan_y", Y, drv ? ys[s*7 +: 7] : 7'd0);
      chk("scan_state", 7'(dbg_state), 7'(drv));
`ifdef SEG7_DP_EN
      chk("scan_dp", 7'(dp), 7'd0);
`endif
      step();
    end
  endtask

  initial begin
    tbl[0]  = '{2'd0, 4'h4, 1'b1, 4'b0001, 7'b1100110};
    tbl[1]  = '{2'd1, 4'h5, 1'b1, 4'b0010, 7'b1101101};
    tbl[2]  = '{2'd2, 4'h6, 1'b1, 4'b0100, 7'b1111101};
    tbl[3]  = '{2'd3, 4'h7, 1'b1, 4'b1000, 7'b0000111};
    tbl[4]  = '{2'd0, 4'h8, 1'b1, 4'b0001, 7'b1111111};
    tbl[5]  = '{2'd1, 4'h9, 1'b1, 4'b0010, 7'b1101111};
    tbl[6]  = '{2'd2, 4'hA, 1'b1, 4'b0100, 7'b1110111};
    tbl[7]  = '{2'd3, 4'hB, 1'b1, 4'b1000, 7'b1111100};
    tbl[8]  = '{2'd0, 4'hC, 1'b1, 4'b0001, 7'b0111001};
    tbl[9]  = '{2'd1, 4'hD, 1'b0, 4'b0000, 7'b0000000};
    tbl[10] = '{2'd2, 4'hE, 1'b1, 4'b0100, 7'b1111001};
    tbl[11] = '{2'd3, 4'h3, 1'b0, 4'b0000, 7'b0000000};
    tbl[12] = '{2'd0, 4'h0, 1'b1, 4'b0001, 7'b0111111};
    tbl[13] = '{2'd1, 4'h1, 1'b1, 4'b0010, 7'b0000110};
    tbl[14] = '{2'd2, 4'h2, 1'b1, 4'b0100, 7'b1011011};
    tbl[15] = '{2'd3, 4'hF, 1'b1, 4'b1000, 7'b1110001};

    // Reset state, then one dark period.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y", Y, 7'd0);
    chk("rst_dig", 7'(Dig), 7'd0);
    chk("rst_ready", 7'(wr_ready), 7'd1);
    rst = 1'b0;
    cyc = 0;
    check_period(16'h0000, 28'h0);

    // Single write of '3' to digit 0 during slot 0 blank.
    write_req(2'd0, 4'h3, 1'b1);
    step();
    chk("w0_ready_back", 7'(wr_ready), 7'd1);
    chk("w0_dig", 7'(Dig), 7'b0001);
    chk("w0_y", Y, 7'b1001111);
    align(0);
    check_period(16'h0001, {7'd0, 7'd0, 7'd0, 7'b1001111});

    // Decoder / enable table, each write made in its digit's blank.
    for (int i = 0; i < 16; i++) begin
      align(int'(tbl[i].digit) * SLOT);
      write_req(tbl[i].digit, tbl[i].value, tbl[i].on);
      step();
      chk("tbl_ready", 7'(wr_ready), 7'd1);
      chk("tbl_dig", 7'(Dig), 7'(tbl[i].exp_dig));
      chk("tbl_y", Y, tbl[i].exp_y);
    end
    align(0);
    check_period(16'h8421, {7'b1110001, 7'b1011011, 7'b0000110, 7'b0111111});

    // Two back-to-back writes with wr_valid held high.
    align(3);
    wr_digit = 2'd0; wr_value = 4'h8; wr_on = 1'b1; wr_valid = 1'b1;
    chk("q_ready_first", 7'(wr_ready), 7'd1);
    step();
    wr_digit = 2'd1; wr_value = 4'h9;
    while (cyc % PER != 9) begin
      chk("q_ready_wait1", 7'(wr_ready), 7'd0);
      if (cyc % PER < 8) begin
        chk("q_y_slot0", Y, 7'b0111111);
        chk("q_dig_slot0", 7'(Dig), 7'b0001);
      end
      step();
    end
    chk("q_ready_after_commit1", 7'(wr_ready), 7'd1);
    step();
    while (cyc % PER != 16) begin
      chk("q_ready_wait2", 7'(wr_ready), 7'd0);
      chk("q_y_slot1", Y, 7'b0000110);
      chk("q_dig_slot1", 7'(Dig), 7'b0010);
      step();
    end
    chk("q_ready_blank2", 7'(wr_ready), 7'd0);
    step();
    chk("q_ready_after_commit2", 7'(wr_ready), 7'd1);
    wr_valid = 1'b0;
    align(0);
    check_period(16'h8421, {7'b1110001, 7'b1011011, 7'b1101111, 7'b1111111});

    // Turn digit 1 off while it is lit.
    align(11);
    write_req(2'd1, 4'h9, 1'b0);
    while (cyc % PER != 16) begin
      chk("off_dig_lit", 7'(Dig), 7'b0010);
      chk("off_y_lit", Y, 7'b1101111);
      step();
    end
    align(0);
    check_period(16'h8401, {7'b1110001, 7'b1011011, 7'd0, 7'b1111111});

    // Reset mid-DRIVE with a pending write.
    align(19);
    write_req(2'd3, 4'h5, 1'b1);
    rst = 1'b1;
    step();
    chk("mrst_y", Y, 7'd0);
    chk("mrst_dig", 7'(Dig), 7'd0);
    chk("mrst_ready", 7'(wr_ready), 7'd1);
    rst = 1'b0;
    cyc = 0;
    check_period(16'h0000, 28'h0);

`ifdef SEG7_DP_EN
    // Decimal point on digit 2 only.
    align(16);
    wr_dp = 1'b1;
    write_req(2'd2, 4'h2, 1'b1);
    wr_dp = 1'b0;
    step();
    for (int k = 0; k < PER; k++) begin
      chk("dp_slot2", 7'(dp), 7'((cyc % PER >= 18) && (cyc % PER <= 23)));
      step();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
